// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the load unit: load op codes, FSM state encoding,
// default address-window constants and small width helpers.
package mem_load_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        DE_lw  = 3'd0,
        DE_lh  = 3'd1,
        DE_lhu = 3'd2,
        DE_lb  = 3'd3,
        DE_lbu = 3'd4
    } de_op_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_BUS   = ST_BUS,
        S_DRAIN = ST_DRAIN,
        S_RESP  = ST_RESP
    } ld_state_e;

    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] DM_END_DEF   = 32'h0000_2fff;
    localparam int          NUM_DEV_DEF  = 2;
    localparam logic [63:0] DEV_BASE_DEF = {32'h0000_7f10, 32'h0000_7f00};
    localparam int          DEV_SIZE_DEF = 12;
    localparam int          TIMEOUT_DEF  = 15;

    // Number of byte-lane address bits inside one bus word.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Timeout counter width; never narrower than 4 bits.
    function automatic int cnt_bits(input int timeout);
        int b;
        b = $clog2(timeout + 1);
        return (b < 4) ? 4 : b;
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Load-unit signal bundle: pipeline request, bus read channel and response.
// slave = the load unit, master = the surrounding pipeline/bus side.
interface mem_load_unit_if #(
    parameter int DATA_W = mem_load_unit_pkg::DATA_W_DEF
);
    import mem_load_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [OP_W-1:0]   req_op;
    logic              req_ovf;
    logic              flush;

    logic              bus_req;
    logic [31:0]       bus_addr;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_adel;
    logic              resp_timeout;

    modport slave (
        input  req_valid, req_addr, req_op, req_ovf, flush,
        input  bus_ack, bus_rdata, resp_ready,
        output req_ready, bus_req, bus_addr,
        output resp_valid, resp_data, resp_adel, resp_timeout
    );

    modport master (
        output req_valid, req_addr, req_op, req_ovf, flush,
        output bus_ack, bus_rdata, resp_ready,
        input  req_ready, bus_req, bus_addr,
        input  resp_valid, resp_data, resp_adel, resp_timeout
    );

endinterface

// File: rtl/mem_load_unit_ld_lane_ext.sv
// Combinational lane extractor: picks the byte/half/word at a lane offset of
// a bus word and sign- or zero-extends it to 32 bits according to the load op.
module ld_lane_ext
    import mem_load_unit_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int LANE_W = lane_bits(DATA_W)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [OP_W-1:0]   i_op,
    output logic [31:0]       o_data
);

    localparam int NB = DATA_W / 8;

    logic [7:0]        w_bytes [NB];
    logic [LANE_W-1:0] w_lane1;
    logic [LANE_W-1:0] w_lane2;
    logic [LANE_W-1:0] w_lane3;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [7:0]        w_b2;
    logic [7:0]        w_b3;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bytes
            assign w_bytes[gi] = i_word[gi*8 +: 8];
        end
    endgenerate

    // Lane offsets wrap inside the word; alignment checks upstream keep
    // half/word accesses from ever actually straddling the word end.
    assign w_lane1 = i_lane + LANE_W'(1);
    assign w_lane2 = i_lane + LANE_W'(2);
    assign w_lane3 = i_lane + LANE_W'(3);

    assign w_b0 = w_bytes[i_lane];
    assign w_b1 = w_bytes[w_lane1];
    assign w_b2 = w_bytes[w_lane2];
    assign w_b3 = w_bytes[w_lane3];

    always_comb begin
        o_data = {w_b3, w_b2, w_b1, w_b0};
        case (i_op)
            DE_lh:   o_data = {{16{w_b1[7]}}, w_b1, w_b0};
            DE_lhu:  o_data = {16'h0000, w_b1, w_b0};
            DE_lb:   o_data = {{24{w_b0[7]}}, w_b0};
            DE_lbu:  o_data = {24'h00_0000, w_b0};
            default: o_data = {w_b3, w_b2, w_b1, w_b0};
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle load unit: checks alignment/address windows, issues a bus read,
// waits for a variable-latency ack and returns the extended result.
// Optional bus timeout enabled with `define MEM_LOAD_TIMEOUT_EN.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int                    DATA_W   = DATA_W_DEF,
    parameter logic [31:0]           DM_END   = DM_END_DEF,
    parameter int                    NUM_DEV  = NUM_DEV_DEF,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = DEV_BASE_DEF,
    parameter int                    DEV_SIZE = DEV_SIZE_DEF,
    parameter int                    TIMEOUT  = TIMEOUT_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mem_load_unit_if.slave io_bus
);

    localparam int LANE_W = lane_bits(DATA_W);

    ld_state_e         r_state;
    logic              r_req_ready;
    logic              r_bus_req;
    logic [31:0]       r_bus_addr;
    logic [LANE_W-1:0] r_lane;
    logic [OP_W-1:0]   r_op;
    logic              r_resp_valid;
    logic [31:0]       r_resp_data;
    logic              r_resp_adel;
    logic              r_resp_timeout;

    logic [NUM_DEV-1:0] w_dev_hit;
    logic               w_in_dm;
    logic               w_in_dev;
    logic               w_misalign;
    logic               w_out_of_range;
    logic               w_dev_subword;
    logic               w_err;
    logic               w_accept;
    logic               w_to_hit;
    logic [31:0]        w_line_addr;
    logic [31:0]        w_ext_data;

    // Address window decode on the incoming request (33-bit to avoid wrap).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            localparam logic [32:0] BASE = {1'b0, DEV_BASE[gi*32 +: 32]};
            localparam logic [32:0] LAST = BASE + 33'(DEV_SIZE - 1);
            assign w_dev_hit[gi] = ({1'b0, io_bus.req_addr} >= BASE) &&
                                   ({1'b0, io_bus.req_addr} <= LAST);
        end
    endgenerate

    assign w_in_dm        = (io_bus.req_addr <= DM_END);
    assign w_in_dev       = |w_dev_hit;
    assign w_out_of_range = !w_in_dm && !w_in_dev;
    assign w_dev_subword  = w_in_dev && (io_bus.req_op != DE_lw);

    always_comb begin
        w_misalign = 1'b1;
        case (io_bus.req_op)
            DE_lw:          w_misalign = |io_bus.req_addr[1:0];
            DE_lh, DE_lhu:  w_misalign = io_bus.req_addr[0];
            DE_lb, DE_lbu:  w_misalign = 1'b0;
            default:        w_misalign = 1'b1;
        endcase
    end

    assign w_err       = w_misalign | w_out_of_range | w_dev_subword | io_bus.req_ovf;
    assign w_accept    = io_bus.req_valid && r_req_ready && !io_bus.flush;
    assign w_line_addr = {io_bus.req_addr[31:LANE_W], {LANE_W{1'b0}}};

`ifdef MEM_LOAD_TIMEOUT_EN
    localparam int CNT_W = cnt_bits(TIMEOUT);

    logic [CNT_W-1:0] r_to_cnt;

    // Counts ack-less bus cycles; keeps running across BUS -> DRAIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_BUS || r_state == S_DRAIN) && !io_bus.bus_ack) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    ld_lane_ext #(
        .DATA_W (DATA_W)
    ) u_lane_ext (
        .i_word (io_bus.bus_rdata),
        .i_lane (r_lane),
        .i_op   (r_op),
        .o_data (w_ext_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_addr     <= '0;
            r_lane         <= '0;
            r_op           <= DE_lw;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_resp_adel    <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_lane      <= io_bus.req_addr[LANE_W-1:0];
                        r_op        <= io_bus.req_op;
                        if (w_err) begin
                            r_state        <= S_RESP;
                            r_resp_valid   <= 1'b1;
                            r_resp_adel    <= 1'b1;
                            r_resp_timeout <= 1'b0;
                            r_resp_data    <= '0;
                        end else begin
                            r_state    <= S_BUS;
                            r_bus_req  <= 1'b1;
                            r_bus_addr <= w_line_addr;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the final counted cycle wins over the timeout.
                    if (io_bus.bus_ack || w_to_hit) begin
                        r_bus_req <= 1'b0;
                        if (io_bus.flush) begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state        <= S_RESP;
                            r_resp_valid   <= 1'b1;
                            r_resp_adel    <= 1'b0;
                            r_resp_timeout <= !io_bus.bus_ack;
                            r_resp_data    <= io_bus.bus_ack ? w_ext_data : 32'h0;
                        end
                    end else if (io_bus.flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (io_bus.bus_ack || w_to_hit) begin
                        r_bus_req   <= 1'b0;
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (io_bus.resp_ready || io_bus.flush) begin
                        r_state        <= S_IDLE;
                        r_req_ready    <= 1'b1;
                        r_resp_valid   <= 1'b0;
                        r_resp_adel    <= 1'b0;
                        r_resp_timeout <= 1'b0;
                        r_resp_data    <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.req_ready    = r_req_ready;
    assign io_bus.bus_req      = r_bus_req;
    assign io_bus.bus_addr     = r_bus_addr;
    assign io_bus.resp_valid   = r_resp_valid;
    assign io_bus.resp_data    = r_resp_data;
    assign io_bus.resp_adel    = r_resp_adel;
    assign io_bus.resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: directed vector table, hand-written flush/timeout/
// reset sequences and randomized loads checked against a reference model.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_load_unit_if #(.DATA_W(32)) bus_if ();

    mem_load_unit #(.DATA_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required summary before limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic        ovf;
        logic [31:0] rdata;
        int          delay;
        int          stall;
        logic        exp_adel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus_if.req_valid  = 1'b0;
        bus_if.req_addr   = 32'h0;
        bus_if.req_op     = 3'd0;
        bus_if.req_ovf    = 1'b0;
        bus_if.flush      = 1'b0;
        bus_if.bus_ack    = 1'b0;
        bus_if.bus_rdata  = 32'h0;
        bus_if.resp_ready = 1'b0;
    endtask

    // Present one request for a single cycle, then scramble the request bus.
    task automatic present(input string nm, input logic [31:0] addr, input logic [2:0] op,
                           input logic ovf);
        check({nm, ".req_ready"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        bus_if.req_op    = op;
        bus_if.req_ovf   = ovf;
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = $urandom;
        bus_if.req_op    = 3'($urandom_range(0, 4));
        bus_if.req_ovf   = 1'($urandom_range(0, 1));
    endtask

    // Reference behaviour from the load rules, using plain arithmetic.
    function automatic void ref_load(input logic [31:0] a, input int op, input bit ovf,
                                     input logic [31:0] rd, output bit adel,
                                     output logic [31:0] d);
        longint unsigned v;
        longint unsigned m;
        int size;
        bit in_dm;
        bit in_dev;
        in_dm  = (a <= 32'h0000_2fff);
        in_dev = (a >= 32'h7f00 && a <= 32'h7f0b) || (a >= 32'h7f10 && a <= 32'h7f1b);
        size   = (op == 0) ? 4 : ((op <= 2) ? 2 : 1);
        adel   = ovf || ((a % size) != 0) || !(in_dm || in_dev) || (in_dev && op != 0);
        d      = 32'h0;
        if (!adel) begin
            m = 64'd1 << (8 * size);
            v = (64'(rd) >> (8 * (a % 4))) % m;
            if ((op == 1 || op == 3) && v >= m / 2) v = v - m;
            d = v[31:0];
        end
    endfunction

    // Full load transaction with ack after 'delay' bus cycles and 'stall'
    // cycles of resp_ready low.
    task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] op,
                            input logic ovf, input logic [31:0] rdata, input int delay,
                            input int stall, input logic exp_adel, input logic [31:0] exp_data);
        present(nm, addr, op, ovf);
        if (exp_adel) begin
            check({nm, ".bus_req"}, 32'(bus_if.bus_req), 32'd0);
        end else begin
            for (int c = 0; c <= delay; c++) begin
                check({nm, ".bus_req"}, 32'(bus_if.bus_req), 32'd1);
                check({nm, ".bus_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
                check({nm, ".early_valid"}, 32'(bus_if.resp_valid), 32'd0);
                if (c == delay) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdata;
                end
                tick();
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = $urandom;
            end
            check({nm, ".bus_req_drop"}, 32'(bus_if.bus_req), 32'd0);
        end
        check({nm, ".resp_valid"}, 32'(bus_if.resp_valid), 32'd1);
        check({nm, ".resp_adel"}, 32'(bus_if.resp_adel), 32'(exp_adel));
        check({nm, ".resp_timeout"}, 32'(bus_if.resp_timeout), 32'd0);
        check({nm, ".resp_data"}, bus_if.resp_data, exp_data);
        $display("txn %s addr=%08h op=%0d ovf=%0b adel=%0b data=%08h", nm, addr, op, ovf,
                 bus_if.resp_adel, bus_if.resp_data);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({nm, ".hold_valid"}, 32'(bus_if.resp_valid), 32'd1);
            check({nm, ".hold_data"}, bus_if.resp_data, exp_data);
            check({nm, ".hold_bus_req"}, 32'(bus_if.bus_req), 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        tick();
        bus_if.resp_ready = 1'b0;
        check({nm, ".valid_clear"}, 32'(bus_if.resp_valid), 32'd0);
        check({nm, ".ready_back"}, 32'(bus_if.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [2:0]  op;
        logic        ovf;
        bit          e_adel;
        logic [31:0] e_data;
        int          sel;
        int          size;

        rst_n = 1'b0;
        set_idle();

        vecs[0]  = '{32'h0000_0003, DE_lb,  1'b0, 32'h8000_0000, 1, 3, 1'b0, 32'hffff_ff80};
        vecs[1]  = '{32'h0000_0003, DE_lbu, 1'b0, 32'h8000_0000, 1, 0, 1'b0, 32'h0000_0080};
        vecs[2]  = '{32'h0000_0002, DE_lw,  1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[3]  = '{32'h0000_7f04, DE_lh,  1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[4]  = '{32'h0000_7f08, DE_lw,  1'b0, 32'hdead_beef, 0, 1, 1'b0, 32'hdead_beef};
        vecs[5]  = '{32'h0000_3000, DE_lw,  1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0000, DE_lw,  1'b1, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{32'h0000_0002, DE_lh,  1'b0, 32'h8765_4321, 2, 0, 1'b0, 32'hffff_8765};
        vecs[8]  = '{32'h0000_0002, DE_lhu, 1'b0, 32'h8765_4321, 0, 0, 1'b0, 32'h0000_8765};
        vecs[9]  = '{32'h0000_0001, DE_lb,  1'b0, 32'h0000_7f00, 0, 0, 1'b0, 32'h0000_007f};
        vecs[10] = '{32'h0000_2ffc, DE_lw,  1'b0, 32'h1234_5678, 3, 0, 1'b0, 32'h1234_5678};
        vecs[11] = '{32'h0000_2fff, DE_lb,  1'b0, 32'h5a00_0000, 0, 0, 1'b0, 32'h0000_005a};
        vecs[12] = '{32'h0000_7f0c, DE_lw,  1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[13] = '{32'h0000_7f18, DE_lw,  1'b0, 32'hc001_d00d, 1, 0, 1'b0, 32'hc001_d00d};
        vecs[14] = '{32'h0000_7f10, DE_lbu, 1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};
        vecs[15] = '{32'h0000_0001, DE_lh,  1'b0, 32'h1111_1111, 0, 0, 1'b1, 32'h0000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(bus_if.req_ready), 32'd0);
        check("rst.bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst.bus_addr", bus_if.bus_addr, 32'd0);
        check("rst.resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("rst.resp_data", bus_if.resp_data, 32'd0);
        check("rst.resp_adel", 32'(bus_if.resp_adel), 32'd0);
        check("rst.resp_timeout", 32'(bus_if.resp_timeout), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.ready_after", 32'(bus_if.req_ready), 32'd1);
        $display("txn reset released req_ready=%0b", bus_if.req_ready);

        for (int i = 0; i < 16; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].op, vecs[i].ovf,
                     vecs[i].rdata, vecs[i].delay, vecs[i].stall, vecs[i].exp_adel,
                     vecs[i].exp_data);
        end

        // No ack: timeout in the build that has it, otherwise ack at cycle 40.
        present("noack", 32'h0000_0100, DE_lw, 1'b0);
`ifdef MEM_LOAD_TIMEOUT_EN
        for (int c = 1; c <= 15; c++) begin
            check("noack.bus_req", 32'(bus_if.bus_req), 32'd1);
            check("noack.early_valid", 32'(bus_if.resp_valid), 32'd0);
            tick();
        end
        check("noack.resp_valid", 32'(bus_if.resp_valid), 32'd1);
        check("noack.resp_timeout", 32'(bus_if.resp_timeout), 32'd1);
        check("noack.resp_adel", 32'(bus_if.resp_adel), 32'd0);
        check("noack.resp_data", bus_if.resp_data, 32'd0);
        check("noack.bus_req_drop", 32'(bus_if.bus_req), 32'd0);
`else
        for (int c = 1; c <= 40; c++) begin
            check("noack.bus_req", 32'(bus_if.bus_req), 32'd1);
            check("noack.early_valid", 32'(bus_if.resp_valid), 32'd0);
            if (c == 40) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = 32'hcafe_f00d;
            end
            tick();
            bus_if.bus_ack = 1'b0;
        end
        check("noack.resp_valid", 32'(bus_if.resp_valid), 32'd1);
        check("noack.resp_timeout", 32'(bus_if.resp_timeout), 32'd0);
        check("noack.resp_data", bus_if.resp_data, 32'hcafe_f00d);
`endif
        $display("txn noack resp_timeout=%0b data=%08h", bus_if.resp_timeout, bus_if.resp_data);
        bus_if.resp_ready = 1'b1;
        tick();
        bus_if.resp_ready = 1'b0;
        check("noack.valid_clear", 32'(bus_if.resp_valid), 32'd0);

        // Flush in BUS cycle 2, ack in cycle 5: drain, then IDLE in cycle 6.
        present("flush_bus", 32'h0000_0040, DE_lw, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            check("flush_bus.bus_req", 32'(bus_if.bus_req), 32'd1);
            check("flush_bus.resp_valid", 32'(bus_if.resp_valid), 32'd0);
            check("flush_bus.req_ready", 32'(bus_if.req_ready), 32'd0);
            bus_if.flush   = (c == 2);
            bus_if.bus_ack = (c == 5);
            tick();
            bus_if.flush   = 1'b0;
            bus_if.bus_ack = 1'b0;
        end
        check("flush_bus.ready_c6", 32'(bus_if.req_ready), 32'd1);
        check("flush_bus.bus_req_c6", 32'(bus_if.bus_req), 32'd0);
        check("flush_bus.valid_c6", 32'(bus_if.resp_valid), 32'd0);
        $display("txn flush_bus req_ready=%0b resp_valid=%0b", bus_if.req_ready, bus_if.resp_valid);

        // Flush together with ack: data discarded, straight back to IDLE.
        present("flush_ack", 32'h0000_0044, DE_lw, 1'b0);
        bus_if.flush     = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h5555_aaaa;
        tick();
        set_idle();
        check("flush_ack.resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("flush_ack.req_ready", 32'(bus_if.req_ready), 32'd1);
        check("flush_ack.bus_req", 32'(bus_if.bus_req), 32'd0);
        $display("txn flush_ack req_ready=%0b", bus_if.req_ready);

        // Flush in IDLE: the same-cycle request is ignored.
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h0000_0048;
        bus_if.req_op    = DE_lw;
        bus_if.flush     = 1'b1;
        tick();
        set_idle();
        check("flush_idle.bus_req", 32'(bus_if.bus_req), 32'd0);
        check("flush_idle.req_ready", 32'(bus_if.req_ready), 32'd1);
        tick();
        check("flush_idle.resp_valid", 32'(bus_if.resp_valid), 32'd0);
        $display("txn flush_idle bus_req=%0b", bus_if.bus_req);

        // Flush in RESP drops the response.
        present("flush_resp", 32'h0000_0002, DE_lw, 1'b0);
        check("flush_resp.valid", 32'(bus_if.resp_valid), 32'd1);
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
        check("flush_resp.dropped", 32'(bus_if.resp_valid), 32'd0);
        check("flush_resp.req_ready", 32'(bus_if.req_ready), 32'd1);
        $display("txn flush_resp resp_valid=%0b", bus_if.resp_valid);

`ifdef MEM_LOAD_TIMEOUT_EN
        // Flush then no ack: drain ends by timeout with no response.
        present("drain_to", 32'h0000_0050, DE_lw, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            check("drain_to.bus_req", 32'(bus_if.bus_req), 32'd1);
            bus_if.flush = (c == 1);
            tick();
            bus_if.flush = 1'b0;
        end
        check("drain_to.bus_req_drop", 32'(bus_if.bus_req), 32'd0);
        check("drain_to.resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("drain_to.req_ready", 32'(bus_if.req_ready), 32'd1);
        $display("txn drain_to req_ready=%0b", bus_if.req_ready);
`endif

        // Asynchronous reset in the middle of a bus access.
        present("mid_rst", 32'h0000_0010, DE_lw, 1'b0);
        check("mid_rst.bus_req_pre", 32'(bus_if.bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst.bus_req", 32'(bus_if.bus_req), 32'd0);
        check("mid_rst.req_ready", 32'(bus_if.req_ready), 32'd0);
        check("mid_rst.resp_valid", 32'(bus_if.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rst.ready_after", 32'(bus_if.req_ready), 32'd1);
        check("mid_rst.bus_req_after", 32'(bus_if.bus_req), 32'd0);
        $display("txn mid_rst req_ready=%0b bus_req=%0b", bus_if.req_ready, bus_if.bus_req);

        // Randomized loads against the reference model.
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 3);
            op  = 3'($urandom_range(0, 4));
            case (sel)
                0:       addr = $urandom_range(0, 32'h2fff);
                1:       addr = (($urandom_range(0, 1) == 1) ? 32'h7f10 : 32'h7f00)
                                + $urandom_range(0, 15);
                2:       addr = $urandom;
                default: addr = 32'h2ff0 + $urandom_range(0, 31);
            endcase
            size = (op == 3'd0) ? 4 : ((op <= 3'd2) ? 2 : 1);
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(size - 1);
            ovf   = ($urandom_range(0, 15) == 0);
            rdata = $urandom;
            ref_load(addr, int'(op), ovf, rdata, e_adel, e_data);
            run_load($sformatf("rnd%0d", t), addr, op, ovf, rdata, $urandom_range(0, 5),
                     $urandom_range(0, 2), e_adel, e_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
